// File: rtl/mem_pkg.sv
// Shared constants and encodings for the Memory_Interface initiator.
package mem_pkg;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 19;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_FILL = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdIssue,
        StRdWait,
        StResp
    } mac_state_e;

endpackage

// File: rtl/mem_access_controller.sv
// Burst master for the Memory_Interface: fills (repeated store) and loads with a
// backpressured response channel. Every output except req_ready is registered.
module mem_access_controller
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W       = mem_pkg::DATA_W,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned LEN_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              done,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LEN_W:0] OneBeat = (LEN_W+1)'(1);
    localparam logic [1:0]     LatInit = 2'(READ_LATENCY - 1);

    mac_state_e        state_q, state_d;
    logic [LEN_W:0]    beats_q, beats_d;
    logic [1:0]        lat_q, lat_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_last_q, resp_last_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        beats_d      = beats_q;
        lat_d        = lat_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_last_d  = resp_last_q;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    beats_d     = {1'b0, req_len} + OneBeat;
                    state_d     = (op_e'(req_write) == OP_FILL) ? StWrite : StRdIssue;
                end
            end
            StWrite: begin
                if (beats_q == OneBeat) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    beats_d    = beats_q - OneBeat;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            StRdIssue: begin
                state_d = StRdWait;
                lat_d   = LatInit;
            end
            StRdWait: begin
                if (lat_q == 2'd0) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = mem_rdata;
                    resp_last_d  = (beats_q == OneBeat);
                    state_d      = StResp;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_last_d  = 1'b0;
                    if (beats_q == OneBeat) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        beats_d    = beats_q - OneBeat;
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                        state_d    = StRdIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Strobes are derived from the next state so they line up with the state register.
        mem_write_d = (state_d == StWrite);
        mem_read_d  = (state_d == StRdIssue);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            beats_q      <= '0;
            lat_q        <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_q      <= beats_d;
            lat_q        <= lat_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_last  = resp_last_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
